fifo_wr_arbiter: RTL

//  Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters in the w_clk domain.

---
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter that shares one async-FIFO write port among
//             NUM_REQ write-side requesters, with bursts capped at MAX_BURST.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int size      = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    w_clk,
    input  logic                    clr,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*size-1:0] req_data,
    input  logic                    fullN,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    w_en,
    output logic [size-1:0]         datain,
    output logic                    busy
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [OW-1:0] C_LAST_INIT = OW'(NUM_REQ - 1);
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_owner_q, last_owner_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;

    logic                pick_valid;
    logic [OW-1:0]       pick_idx;
    logic                owner_req;
    logic [size-1:0]     owner_data;
    logic                wr_fire;

    // Search downward so the candidate closest to last_owner+1 is assigned last and wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_owner_q) + k) % NUM_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = OW'((int'(last_owner_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        owner_req  = req[owner_q];
        owner_data = req_data[int'(owner_q)*size +: size];
    end

    assign wr_fire = (state_q == ST_GRANT) & owner_req & fullN;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                end
            end
            ST_GRANT: begin
                if (!owner_req || (wr_fire && (cnt_q == C_LAST_BEAT))) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    cnt_d        = '0;
                    gnt_d        = '0;
                end else if (wr_fire) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge w_clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= C_LAST_INIT;
            cnt_q        <= '0;
            gnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign w_en   = wr_fire;
    assign datain = wr_fire ? owner_data : '0;
    assign busy   = (state_q == ST_GRANT);

endmodule
`default_nettype wire
